// File: rtl/regfile_sb.sv
// Multi-ported register file with a per-register busy scoreboard.
// Reads and busy lookups are combinational; busy_cnt is a registered popcount of the busy vector.
module regfile_sb #(
    parameter int DATA     = 32,
    parameter int ADDR     = 5,
    parameter int READ     = 4,
    parameter int WRITE    = 2,
    parameter int ISSUE    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [READ-1:0][ADDR-1:0]   raddr,
    output logic [READ-1:0][DATA-1:0]   rdata,
    output logic [READ-1:0]             rbusy,
    input  logic [WRITE-1:0][ADDR-1:0]  waddr,
    input  logic [WRITE-1:0]            we,
    input  logic [WRITE-1:0][DATA-1:0]  wdata,
    input  logic [ISSUE-1:0]            set_en,
    input  logic [ISSUE-1:0][ADDR-1:0]  set_addr,
    input  logic                        flush,
    output logic [ADDR:0]               busy_cnt
);
    localparam int DEPTH = 2 ** ADDR;

    logic [DEPTH-1:0][DATA-1:0] regs_r;
    logic [DEPTH-1:0]           busy_r;
    logic [DEPTH-1:0]           busy_nxt_s;
    logic [ADDR:0]              busy_cnt_r;
    logic [WRITE-1:0]           eff_we_s;
    logic [ISSUE-1:0]           eff_set_s;

    function automatic logic [ADDR:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{ADDR{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Qualify write and reserve requests; register 0 is never a target when hard-wired.
    always_comb begin
        eff_we_s  = '0;
        eff_set_s = '0;
        for (int w = 0; w < WRITE; w++) begin
            eff_we_s[w] = we[w] && !((ZERO_REG != 0) && (waddr[w] == '0));
        end
        for (int i = 0; i < ISSUE; i++) begin
            eff_set_s[i] = set_en[i] && !((ZERO_REG != 0) && (set_addr[i] == '0));
        end
    end

    // Next busy vector: writes clear, then reserves set (new producer wins), then flush clears all.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int w = 0; w < WRITE; w++) begin
            busy_nxt_s[waddr[w]] = eff_we_s[w] ? 1'b0 : busy_nxt_s[waddr[w]];
        end
        for (int i = 0; i < ISSUE; i++) begin
            busy_nxt_s[set_addr[i]] = eff_set_s[i] ? 1'b1 : busy_nxt_s[set_addr[i]];
        end
        busy_nxt_s = flush ? '0 : busy_nxt_s;
    end

    // Register data: ascending port order so the highest-index writer lands last.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_r <= '0;
        end else begin
            for (int w = 0; w < WRITE; w++) begin
                if (eff_we_s[w]) begin
                    regs_r[waddr[w]] <= wdata[w];
                end
            end
        end
    end

    // Busy state and its registered population count.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r     <= '0;
            busy_cnt_r <= '0;
        end else begin
            busy_r     <= busy_nxt_s;
            busy_cnt_r <= popcount(busy_nxt_s);
        end
    end

    // Read ports with same-cycle forwarding; a forwarded value is by definition no longer busy.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int r = 0; r < READ; r++) begin
            rdata[r] = regs_r[raddr[r]];
            rbusy[r] = busy_r[raddr[r]];
            for (int w = 0; w < WRITE; w++) begin
                rdata[r] = ((BYPASS != 0) && eff_we_s[w] && (waddr[w] == raddr[r])) ? wdata[w] : rdata[r];
                rbusy[r] = ((BYPASS != 0) && eff_we_s[w] && (waddr[w] == raddr[r])) ? 1'b0 : rbusy[r];
            end
            rdata[r] = ((ZERO_REG != 0) && (raddr[r] == '0)) ? '0 : rdata[r];
            rbusy[r] = ((ZERO_REG != 0) && (raddr[r] == '0)) ? 1'b0 : rbusy[r];
        end
    end

    assign busy_cnt = busy_cnt_r;
endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: expectations from a behavioural model are queued when
// inputs are driven and popped against the DUT outputs later in the same cycle.
module tb_regfile_sb;
    localparam int DATA  = 32;
    localparam int ADDR  = 5;
    localparam int READ  = 4;
    localparam int WRITE = 2;
    localparam int ISSUE = 2;
    localparam int DEPTH = 32;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [READ-1:0][ADDR-1:0]  raddr;
    logic [READ-1:0][DATA-1:0]  rdata;
    logic [READ-1:0]            rbusy;
    logic [WRITE-1:0][ADDR-1:0] waddr;
    logic [WRITE-1:0]           we;
    logic [WRITE-1:0][DATA-1:0] wdata;
    logic [ISSUE-1:0]           set_en;
    logic [ISSUE-1:0][ADDR-1:0] set_addr;
    logic                       flush;
    logic [ADDR:0]              busy_cnt;

    regfile_sb #(.DATA(DATA), .ADDR(ADDR), .READ(READ), .WRITE(WRITE), .ISSUE(ISSUE),
                 .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .waddr(waddr), .we(we), .wdata(wdata), .set_en(set_en), .set_addr(set_addr),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t             sbq[$];
    int               checks   = 0;
    int               failures = 0;
    logic [DATA-1:0]  m_regs[DEPTH];
    logic [DEPTH-1:0] m_busy;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int popc(input logic [DEPTH-1:0] v);
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic push_expect();
        exp_t e;
        for (int r = 0; r < READ; r++) begin
            logic [DATA-1:0] d;
            logic            b;
            d = m_regs[raddr[r]];
            b = m_busy[raddr[r]];
            for (int w = WRITE - 1; w >= 0; w--) begin
                if (we[w] && waddr[w] != 0 && waddr[w] == raddr[r]) begin
                    d = wdata[w];
                    b = 1'b0;
                    break;
                end
            end
            if (raddr[r] == 0) begin
                d = '0;
                b = 1'b0;
            end
            e.tag = $sformatf("rdata%0d@%0d", r, raddr[r]); e.exp = 64'(d); sbq.push_back(e);
            e.tag = $sformatf("rbusy%0d@%0d", r, raddr[r]); e.exp = 64'(b); sbq.push_back(e);
        end
        e.tag = "busy_cnt"; e.exp = 64'(popc(m_busy)); sbq.push_back(e);
    endtask

    task automatic compare_outputs();
        exp_t e;
        for (int r = 0; r < READ; r++) begin
            for (int k = 0; k < 2; k++) begin
                if (sbq.size() == 0) begin
                    check_eq("queue_underflow", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check_eq(e.tag, (k == 0) ? 64'(rdata[r]) : 64'(rbusy[r]), e.exp);
                end
            end
        end
        if (sbq.size() == 0) begin
            check_eq("queue_underflow", 64'd1, 64'd0);
        end else begin
            e = sbq.pop_front();
            check_eq(e.tag, 64'(busy_cnt), e.exp);
        end
    endtask

    task automatic model_update();
        logic [DEPTH-1:0] nb;
        if (reset) begin
            for (int a = 0; a < DEPTH; a++) m_regs[a] = '0;
            m_busy = '0;
        end else begin
            nb = m_busy;
            for (int w = 0; w < WRITE; w++) begin
                if (we[w] && waddr[w] != 0) begin
                    m_regs[waddr[w]] = wdata[w];
                    nb[waddr[w]] = 1'b0;
                end
            end
            for (int i = 0; i < ISSUE; i++) begin
                if (set_en[i] && set_addr[i] != 0) nb[set_addr[i]] = 1'b1;
            end
            if (flush) nb = '0;
            m_busy = nb;
        end
    endtask

    task automatic cycle();
        #1;
        push_expect();
        compare_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; we = '0; wdata = '0; waddr = '0;
        set_en = '0; set_addr = '0; flush = 1'b0;
    endtask

    initial begin
        int cnt_before;
        idle();
        raddr = '0;
        reset = 1'b1;
        @(posedge clk);
        model_update();
        #1;
        cycle();
        reset = 1'b0;

        // all addresses read zero / not busy after reset
        for (int g = 0; g < DEPTH / READ; g++) begin
            for (int r = 0; r < READ; r++) raddr[r] = ADDR'(g * READ + r);
            cycle();
        end
        check_eq("reset_busy_cnt", 64'(busy_cnt), 64'd0);

        // two writers to reg 7: higher port wins, also via bypass
        raddr = '0; raddr[0] = 5'd7;
        we = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7;
        wdata[0] = 32'hAAAA0000; wdata[1] = 32'h5555FFFF;
        #1 check_eq("bypass_r7", 64'(rdata[0]), 64'h5555FFFF);
        cycle();
        idle();
        #1 check_eq("stored_r7", 64'(rdata[0]), 64'h5555FFFF);
        cycle();

        // reg 0 is hard-wired: write and reserve both ignored
        cnt_before = popc(m_busy);
        raddr[0] = 5'd0;
        we[0] = 1'b1; waddr[0] = 5'd0; wdata[0] = 32'hDEADBEEF;
        set_en[0] = 1'b1; set_addr[0] = 5'd0;
        #1 check_eq("r0_data_same_cycle", 64'(rdata[0]), 64'd0);
        check_eq("r0_busy_same_cycle", 64'(rbusy[0]), 64'd0);
        cycle();
        idle();
        #1 check_eq("r0_data", 64'(rdata[0]), 64'd0);
        check_eq("r0_cnt_unchanged", 64'(busy_cnt), 64'(cnt_before));
        cycle();

        // set beats clear on the same register
        set_en = 2'b11; set_addr[0] = 5'd3; set_addr[1] = 5'd5;
        cycle();
        idle();
        #1 check_eq("cnt_after_set35", 64'(busy_cnt), 64'd2);
        raddr[1] = 5'd3;
        we[0] = 1'b1; waddr[0] = 5'd3; wdata[0] = 32'h00000033;
        set_en[0] = 1'b1; set_addr[0] = 5'd3;
        cycle();
        idle();
        #1 check_eq("busy3_kept", 64'(rbusy[1]), 64'd1);
        check_eq("cnt_kept_2", 64'(busy_cnt), 64'd2);
        we[1] = 1'b1; waddr[1] = 5'd5; wdata[1] = 32'h00000055;
        cycle();
        idle();
        #1 check_eq("cnt_after_w5", 64'(busy_cnt), 64'd1);
        cycle();

        // flush overrides a simultaneous reserve; data untouched
        set_en = 2'b11; set_addr[0] = 5'd1; set_addr[1] = 5'd2;
        cycle();
        set_en = 2'b01; set_addr[0] = 5'd4;
        cycle();
        idle();
        flush = 1'b1; set_en = 2'b01; set_addr[0] = 5'd6;
        cycle();
        idle();
        raddr[0] = 5'd7; raddr[1] = 5'd6; raddr[2] = 5'd3; raddr[3] = 5'd5;
        #1 check_eq("flush_cnt", 64'(busy_cnt), 64'd0);
        check_eq("flush_busy6", 64'(rbusy[1]), 64'd0);
        check_eq("flush_r7_kept", 64'(rdata[0]), 64'h5555FFFF);
        check_eq("flush_r3_kept", 64'(rdata[2]), 64'h00000033);
        cycle();

        // random traffic
        for (int n = 0; n < 300; n++) begin
            for (int r = 0; r < READ; r++) raddr[r] = ADDR'($urandom_range(DEPTH - 1));
            for (int w = 0; w < WRITE; w++) begin
                we[w] = 1'($urandom_range(1));
                waddr[w] = ADDR'($urandom_range(7));
                wdata[w] = DATA'($urandom);
            end
            for (int i = 0; i < ISSUE; i++) begin
                set_en[i] = 1'($urandom_range(1));
                set_addr[i] = ADDR'($urandom_range(DEPTH - 1));
            end
            flush = ($urandom_range(19) == 0);
            cycle();
        end

        // reset wins over concurrent writes and reserves
        idle();
        set_en = 2'b11; set_addr[0] = 5'd9; set_addr[1] = 5'd10;
        cycle();
        reset = 1'b1; we = 2'b11; waddr[0] = 5'd9; waddr[1] = 5'd11;
        wdata[0] = 32'h12345678; wdata[1] = 32'h9ABCDEF0;
        set_en = 2'b11; set_addr[0] = 5'd12; set_addr[1] = 5'd13; flush = 1'b0;
        cycle();
        idle();
        raddr[0] = 5'd9; raddr[1] = 5'd11; raddr[2] = 5'd12; raddr[3] = 5'd7;
        #1 check_eq("rst_cnt", 64'(busy_cnt), 64'd0);
        check_eq("rst_r9", 64'(rdata[0]), 64'd0);
        check_eq("rst_r11", 64'(rdata[1]), 64'd0);
        check_eq("rst_busy12", 64'(rbusy[2]), 64'd0);
        check_eq("rst_r7", 64'(rdata[3]), 64'd0);
        for (int g = 0; g < DEPTH / READ; g++) begin
            for (int r = 0; r < READ; r++) raddr[r] = ADDR'(g * READ + r);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR, default 5: address width; DEPTH = 2**ADDR registers.
REQ-003 SHALL have parameter READ, default 4: number of read ports.
REQ-004 SHALL have parameter WRITE, default 2: number of write ports.
REQ-005 SHALL have parameter ISSUE, default 2: number of busy-set (scoreboard reserve) ports.
REQ-006 SHALL have parameter ZERO_REG, default 1: when 1, register 0 is hard-wired zero.
REQ-007 SHALL have parameter BYPASS, default 1: when 1, same-cycle write data is forwarded to reads.
REQ-008 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-009 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-010 SHALL have port raddr  input  READ x ADDR  read addresses.
REQ-011 SHALL have port rdata  output  READ x DATA  read data.
REQ-012 SHALL have port rbusy  output  READ  busy status of each read address.
REQ-013 SHALL have port waddr  input  WRITE x ADDR  write addresses.
REQ-014 SHALL have port we  input  WRITE  write enables.
REQ-015 SHALL have port wdata  input  WRITE x DATA  write data.
REQ-016 SHALL have port set_en  input  ISSUE  reserve-request enables.
REQ-017 SHALL have port set_addr  input  ISSUE x ADDR  registers to mark busy.
REQ-018 SHALL have port flush  input  1  clear all busy bits.
REQ-019 SHALL have port busy_cnt  output  ADDR+1  count of registers currently busy.

Function
REQ-020 SHALL hold DEPTH data registers and DEPTH busy bits.
REQ-021 SHALL qualify writes: eff_we[w] = we[w], and with ZERO_REG=1 also waddr[w] != 0.
REQ-022 SHALL write wdata[w] to regs[waddr[w]] at the clock edge when eff_we[w]; all other registers hold.
REQ-023 SHALL resolve multiple eff_we to one address by highest-index port winning.
REQ-024 SHALL read combinationally: rdata[r] = regs[raddr[r]] (zero latency).
REQ-025 SHALL, with BYPASS=1, return wdata of the highest-index port with eff_we and waddr == raddr[r] instead of stored data.
REQ-026 SHALL, with ZERO_REG=1, return rdata 0 and rbusy 0 for raddr 0 regardless of writes or sets.
REQ-027 SHALL set busy[set_addr[i]] at the edge when set_en[i] (address 0 ignored when ZERO_REG=1).
REQ-028 SHALL clear busy[waddr[w]] at the edge when eff_we[w].
REQ-029 SHALL give set priority over clear on the same address in the same cycle (new producer reserved).
REQ-030 SHALL clear all busy bits on flush, overriding any set or clear that cycle; register data unaffected.
REQ-031 SHALL drive rbusy[r] = busy[raddr[r]], and with BYPASS=1 force 0 when a same-cycle eff_we matches raddr[r].
REQ-032 SHALL register busy_cnt as the population count of the busy vector after each update (value visible one cycle after the edge, same as busy).
REQ-033 SHALL treat duplicate set_addr in one cycle as a single set; busy_cnt never exceeds DEPTH (or DEPTH-1 with ZERO_REG=1).

Reset
REQ-034 SHALL, when reset=1 at a clock edge, clear all registers, all busy bits and busy_cnt to 0.
REQ-035 SHALL give reset priority over we, set_en and flush in the same cycle.
REQ-036 SHALL present rdata = 0, rbusy = 0, busy_cnt = 0 after reset with BYPASS inactive.

Verification
REQ-037 Reset, then read all addresses -> rdata 0, rbusy 0, busy_cnt 0.
REQ-038 Ports 0 and 1 write 0xAAAA0000 and 0x5555FFFF to reg 7 same cycle -> next cycle rdata 0x5555FFFF; with BYPASS=1 same-cycle read of 7 returns 0x5555FFFF.
REQ-039 Write 0xDEADBEEF to reg 0 with ZERO_REG=1 and set_en on addr 0 -> rdata 0, rbusy 0, busy_cnt unchanged.
REQ-040 set reg 3 and reg 5 (busy_cnt 2); next cycle write reg 3 while setting reg 3 -> busy[3] stays 1, busy_cnt 2; write reg 5 alone -> busy_cnt 1.
REQ-041 Busy regs 1,2,4 then flush with simultaneous set of reg 6 -> all busy 0, busy_cnt 0, register data unchanged.
REQ-042 Mid-operation reset asserted with we and set_en active -> next cycle all registers 0, busy_cnt 0.
